inert_seq: RTL
==============

Name: inert_seq

Overview:
Command sequencer that sits directly upstream of the 16-bit SPI master: it drives wrt/cmd and consumes done/rd_data.
- After reset it waits for sensor power-up, then issues a fixed 4-command configuration write sequence to the inertial sensor.
- It then services each sensor data-ready interrupt by issuing 4 register reads.
- From those reads it assembles 16-bit pitch-rate and Z-acceleration words and presents them with a one-cycle valid pulse.

Parameters:
INIT_WAIT_W, 16, width of power-up wait timer; init writes begin when timer reaches all-ones (2^W-1 cycles after reset release). Benches use 4.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
INT  input  1  sensor data-ready, asynchronous, active-high
done  input  1  SPI master transaction complete; held high until next wrt
rd_data  input  16  SPI master read data; bits [7:0] hold register contents
wrt  output  1  one-cycle pulse starting an SPI transaction
cmd  output  16  SPI command word, valid in the wrt cycle and held until next wrt
ptch_rt  output  16  signed pitch rate {high byte, low byte}
az  output  16  signed Z acceleration {high byte, low byte}
vld  output  1  one-cycle pulse; ptch_rt/az updated in the same cycle
init_done  output  1  high once all init writes have completed; sticky until reset

Behaviour:
- Reset values: wrt=0, cmd=16'h0000, ptch_rt=0, az=0, vld=0, init_done=0, timer=0, state=PWR_WAIT, pending=0.
- Reset asserted mid-operation aborts immediately. The full power-up wait and init sequence repeat after release.
- INT path: 2-flop synchronizer, then rising-edge detect giving a 1-cycle int_rise. Min latency is 3 clk from INT rise to int_rise.
  - int_rise sets a pending flag.
  - pending clears when a read sequence starts.
  - An edge arriving while busy, or before init_done, stays pending and is serviced on return to IDLE. Multiple edges collapse into one.
- Init commands, index 0..3: 16'h0D02 (INT1 on data-ready), 16'h1160 (gyro 416 Hz), 16'h1050 (accel 208 Hz), 16'h1460 (rounding).
- Read commands, index 0..3: 16'hA200 (pitch L), 16'hA300 (pitch H), 16'hAC00 (az L), 16'hAD00 (az H). Bit 15 = read.
- Each SPI transaction uses the same handshake:
  - In an *_WR state, drive cmd and pulse wrt for exactly 1 cycle.
  - Move to *_WAIT. The master clears done on the wrt edge, so done is sampled only from the cycle after wrt.
  - When done==1 in *_WAIT, the transaction is complete.
- State machine:
  - PWR_WAIT: timer increments each clk. When timer==all-ones -> INIT_WR with idx=0.
  - INIT_WR: cmd=init[idx], wrt=1 -> INIT_WAIT.
  - INIT_WAIT: on done:
    - if idx==3: set init_done -> IDLE.
    - else: idx+1 -> INIT_WR.
  - IDLE: if pending -> RD_WR with idx=0, clear pending.
  - RD_WR: cmd=rd[idx], wrt=1 -> RD_WAIT.
  - RD_WAIT: on done, capture rd_data[7:0] into byte reg[idx]; then
    - if idx==3: assert vld for 1 cycle -> IDLE.
    - else: idx+1 -> RD_WR.
- ptch_rt={byte1,byte0} and az={byte3,byte2} load on the same edge that vld is asserted. Outputs hold between updates.
- Read latency from int_rise in IDLE to vld: 4 transactions + 5 cycles of sequencer overhead.
- idx is a 2-bit counter that wraps 3->0 implicitly. It is reset to 0 on entry to each sequence.
- wrt never asserts in PWR_WAIT, IDLE or *_WAIT states. Never two wrt pulses without an intervening done.
- rd_data[15:8] is ignored.

Decomposition:
- Package inert_pkg:
  - state_t enum {PWR_WAIT, INIT_WR, INIT_WAIT, IDLE, RD_WR, RD_WAIT};
  - localparam arrays INIT_CMD[4] and RD_CMD[4].
- One sub-module: int_sync (2-flop synchronizer + rising-edge detect, output int_rise).
- Bench pairs inert_seq with the SPI master and a behavioural SPI slave model.

Test Plan:
- INIT_WAIT_W=4, release reset, no INT:
  - first wrt exactly 15 clk after release, cmd=16'h0D02;
  - subsequent cmds in order 0D02, 1160, 1050, 1460, each only after done;
  - init_done rises after 4th done; no further wrt.
- INT pulses after init, slave returns 8'h34, 8'h12, 8'hCD, 8'hAB:
  - read cmds in order A200, A300, AC00, AD00;
  - single vld pulse with ptch_rt=16'h1234 and az=16'hABCD.
- INT raised during init and again during a read sequence:
  - exactly one read sequence after init_done;
  - exactly one further sequence immediately after the in-progress one;
  - INT held high continuously produces no retrigger.
- Stale done: done held high from a prior transaction when wrt pulses:
  - sequencer does not advance in the wrt cycle;
  - it advances only on the next done assertion.
- Assert rst_n low during RD_WAIT of the 3rd read:
  - all outputs return to reset values asynchronously;
  - the full PWR_WAIT and init sequence repeats after release;
  - no vld is produced for the aborted read.
- Read data 8'h00, 8'h80, 8'hFF, 8'h7F -> ptch_rt=16'h8000, az=16'h7FFF; sign is preserved and byte order is checked.

Source files
------------

// File: rtl/inert_pkg.sv
// Shared types and command tables for the inertial-sensor command sequencer.
package inert_pkg;

    typedef enum logic [2:0] {
        PWR_WAIT,
        INIT_WR,
        INIT_WAIT,
        IDLE,
        RD_WR,
        RD_WAIT
    } state_t;

    localparam int N_CMD = 4;

    // Configuration writes: INT1 on data-ready, gyro 416 Hz, accel 208 Hz, rounding.
    localparam logic [15:0] INIT_CMD [N_CMD] = '{16'h0D02, 16'h1160, 16'h1050, 16'h1460};

    // Register reads: pitch L, pitch H, az L, az H (bit 15 selects read).
    localparam logic [15:0] RD_CMD [N_CMD] = '{16'hA200, 16'hA300, 16'hAC00, 16'hAD00};

endpackage

// File: rtl/inert_seq_int_sync.sv
// Brings the asynchronous data-ready interrupt into clk and emits a one-cycle
// pulse per rising edge (three clocks after INT rises, at the earliest).
module int_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic int_async,
    output logic int_rise
);

    logic [2:0] sync_reg;
    logic       int_rise_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg     <= '0;
            int_rise_reg <= 1'b0;
        end else begin
            sync_reg     <= {sync_reg[1:0], int_async};
            int_rise_reg <= sync_reg[1] & ~sync_reg[2];
        end
    end

    assign int_rise = int_rise_reg;

endmodule

// File: rtl/inert_seq.sv
// Sequencer upstream of the SPI master: power-up wait, four config writes,
// then four register reads per data-ready interrupt to build ptch_rt and az.
module inert_seq
    import inert_pkg::*;
#(
    parameter int INIT_WAIT_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [15:0] ptch_rt,
    output logic [15:0] az,
    output logic        vld,
    output logic        init_done
);

    state_t                 state_reg, state_next;
    logic [1:0]             idx_reg, idx_next;
    logic [INIT_WAIT_W-1:0] timer_reg, timer_next;
    logic                   pending_reg, pending_next;
    logic                   wrt_reg, wrt_next;
    logic [15:0]            cmd_reg, cmd_next;
    logic                   init_done_reg, init_done_next;
    logic                   vld_reg;
    logic [15:0]            ptch_reg, az_reg;
    logic                   int_rise, seq_start, cap_en, last_rd;
    logic                   unused_rd_hi;

    assign unused_rd_hi = ^rd_data[15:8];

    int_sync u_int_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .int_async(INT),
        .int_rise (int_rise)
    );

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        timer_next     = timer_reg;
        init_done_next = init_done_reg;
        seq_start      = 1'b0;
        cap_en         = 1'b0;
        last_rd        = 1'b0;
        unique case (state_reg)
            PWR_WAIT: begin
                timer_next = timer_reg + 1'b1;
                // Leave on the edge the timer becomes all-ones so the first wrt
                // lands 2^W-1 clocks after reset release.
                if (&timer_next) begin
                    state_next = INIT_WR;
                    idx_next   = '0;
                end
            end
            INIT_WR:   state_next = INIT_WAIT;
            INIT_WAIT: begin
                if (done) begin
                    if (idx_reg == 2'd3) begin
                        init_done_next = 1'b1;
                        state_next     = IDLE;
                    end else begin
                        idx_next   = idx_reg + 1'b1;
                        state_next = INIT_WR;
                    end
                end
            end
            IDLE: begin
                if (pending_reg) begin
                    seq_start  = 1'b1;
                    idx_next   = '0;
                    state_next = RD_WR;
                end
            end
            RD_WR:     state_next = RD_WAIT;
            RD_WAIT: begin
                if (done) begin
                    cap_en = 1'b1;
                    if (idx_reg == 2'd3) begin
                        last_rd    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        idx_next   = idx_reg + 1'b1;
                        state_next = RD_WR;
                    end
                end
            end
            default:   state_next = PWR_WAIT;
        endcase

        // A new edge in the same cycle a sequence starts must survive the clear.
        pending_next = int_rise | (pending_reg & ~seq_start);

        wrt_next = (state_next == INIT_WR) || (state_next == RD_WR);
        cmd_next = cmd_reg;
        if (state_next == INIT_WR) begin
            cmd_next = INIT_CMD[idx_next];
        end else if (state_next == RD_WR) begin
            cmd_next = RD_CMD[idx_next];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= PWR_WAIT;
            idx_reg       <= '0;
            timer_reg     <= '0;
            pending_reg   <= 1'b0;
            wrt_reg       <= 1'b0;
            cmd_reg       <= '0;
            init_done_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            timer_reg     <= timer_next;
            pending_reg   <= pending_next;
            wrt_reg       <= wrt_next;
            cmd_reg       <= cmd_next;
            init_done_reg <= init_done_next;
        end
    end

    // Bytes 0..2 are held; byte 3 goes straight from rd_data into az.
    for (genvar gi = 0; gi < 3; gi++) begin : g_byte
        logic [7:0] byte_reg;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                byte_reg <= '0;
            end else if (cap_en && (idx_reg == 2'(gi))) begin
                byte_reg <= rd_data[7:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_reg  <= 1'b0;
            ptch_reg <= '0;
            az_reg   <= '0;
        end else begin
            vld_reg <= last_rd;
            if (last_rd) begin
                ptch_reg <= {g_byte[1].byte_reg, g_byte[0].byte_reg};
                az_reg   <= {rd_data[7:0], g_byte[2].byte_reg};
            end
        end
    end

    assign wrt       = wrt_reg;
    assign cmd       = cmd_reg;
    assign ptch_rt   = ptch_reg;
    assign az        = az_reg;
    assign vld       = vld_reg;
    assign init_done = init_done_reg;

endmodule
